// File: rtl/hazard3_fetch_sram_responder_pkg.sv
// Shared hazard3 definitions: data-phase state encodings and the wait-state counter width.
package hazard3_fetch_sram_responder_pkg;

    localparam int W_WAIT_CTR = 3;

    typedef enum logic [1:0] {
        DPH_IDLE = 2'd0,
        DPH_WAIT = 2'd1,
        DPH_RESP = 2'd2
    } dph_state_t;

endpackage

// File: rtl/hazard3_fetch_sram_responder_if.sv
// Instruction-fetch port between the frontend (master) and the SRAM responder (slave).
interface hazard3_fetch_sram_responder_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              mem_size;
    logic [W_ADDR-1:0] mem_addr;
    logic              mem_addr_vld;
    logic              mem_addr_rdy;
    logic [W_DATA-1:0] mem_data;
    logic              mem_data_vld;
    logic              stall_req;

    modport master (
        output mem_size, mem_addr, mem_addr_vld, stall_req,
        input  mem_addr_rdy, mem_data, mem_data_vld
    );

    modport slave (
        input  mem_size, mem_addr, mem_addr_vld, stall_req,
        output mem_addr_rdy, mem_data, mem_data_vld
    );
endinterface

// File: rtl/hazard3_sram_1rw.sv
// Single-port synchronous SRAM with byte-masked write; read data register only moves on ren.
module hazard3_sram_1rw #(
    parameter int DEPTH_WORDS = 1024,
    parameter int W_INDEX     = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ren,
    input  logic               wen,
    input  logic [W_INDEX-1:0] addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wmask,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Array contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hazard3_fetch_sram_responder.sv
// Fetch-port responder for a tightly-coupled instruction SRAM: one outstanding data phase,
// programmable wait states, stall injection and a priority load port.
module hazard3_fetch_sram_responder
    import hazard3_fetch_sram_responder_pkg::*;
#(
    parameter int              W_ADDR      = 32,
    parameter int              W_DATA      = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [W_ADDR-1:0] BASE_ADDR = '0,
    parameter int              WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard3_fetch_sram_responder_if.slave bus,
    input  logic                 ld_wen,
    input  logic [W_ADDR-1:0]    ld_addr,
    input  logic [31:0]          ld_wdata,
    input  logic [3:0]           ld_wmask
);

    localparam int                W_INDEX = $clog2(DEPTH_WORDS);
    localparam logic [W_ADDR-1:0] SPAN    = W_ADDR'(4 * DEPTH_WORDS);
    localparam logic [W_WAIT_CTR-1:0] WS  = W_WAIT_CTR'(WAIT_STATES);

    dph_state_t            state_q, state_d;
    logic [W_WAIT_CTR-1:0] wait_q, wait_d;
    logic                  oor_q;

    logic [W_ADDR-1:0]  fetch_offset;
    logic [W_ADDR-1:0]  ld_offset;
    logic               fetch_oor;
    logic               ld_in_range;
    logic               hready;
    logic               accept;
    logic               sram_ren;
    logic               sram_wen;
    logic [W_INDEX-1:0] sram_addr;
    logic [31:0]        sram_rdata;
    logic               unused_size;

    // Fetch size only matters to the frontend: the full aligned word is always returned.
    assign unused_size = bus.mem_size;

    // Offsets wrap below BASE_ADDR, so one unsigned compare covers both range edges.
    assign fetch_offset = bus.mem_addr - BASE_ADDR;
    assign ld_offset    = ld_addr - BASE_ADDR;
    assign fetch_oor    = !(fetch_offset < SPAN);
    assign ld_in_range  = ld_offset < SPAN;

    assign hready           = (state_q == DPH_IDLE) || (state_q == DPH_RESP && !bus.stall_req);
    assign bus.mem_data_vld = (state_q != DPH_IDLE) && hready;
    assign bus.mem_addr_rdy = hready && !ld_wen;
    assign accept           = bus.mem_addr_vld && bus.mem_addr_rdy;

    // The load port owns the single SRAM port whenever it writes; accept is blocked then.
    assign sram_wen  = ld_wen && ld_in_range;
    assign sram_ren  = accept && !fetch_oor;
    assign sram_addr = ld_wen ? ld_offset[W_INDEX+1:2] : fetch_offset[W_INDEX+1:2];

    assign bus.mem_data = oor_q ? '0 : W_DATA'(sram_rdata);

    hazard3_sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .W_INDEX     (W_INDEX)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .ren   (sram_ren),
        .wen   (sram_wen),
        .addr  (sram_addr),
        .wdata (ld_wdata),
        .wmask (ld_wmask),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DPH_IDLE;
            wait_q  <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                oor_q <= fetch_oor;
            end
        end
    end

    // WAIT always has wait_q>0; stalls only extend RESP, so the counter ignores stall_req.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            DPH_IDLE: ;
            DPH_WAIT: begin
                wait_d = wait_q - W_WAIT_CTR'(1);
                if (wait_q == W_WAIT_CTR'(1)) begin
                    state_d = DPH_RESP;
                end
            end
            DPH_RESP: begin
                if (hready) begin
                    state_d = DPH_IDLE;
                end
            end
            default: state_d = DPH_IDLE;
        endcase
        if (accept) begin
            state_d = (WAIT_STATES > 0) ? DPH_WAIT : DPH_RESP;
            wait_d  = WS;
        end
    end

endmodule
